// File: rtl/ysyx_23060208_sram_rd_arbiter.sv
// Two-master AXI4-Lite read arbiter: IFU (m0) and LSU (m1) share one SRAM read port.
// One outstanding read at a time; the LSU wins when both request in the same idle cycle.
module ysyx_23060208_sram_rd_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] m0_araddr,
  input  logic                  m0_arvalid,
  output logic                  m0_arready,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [1:0]            m0_rresp,
  output logic                  m0_rvalid,
  input  logic                  m0_rready,
  input  logic [DATA_WIDTH-1:0] m1_araddr,
  input  logic                  m1_arvalid,
  output logic                  m1_arready,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [1:0]            m1_rresp,
  output logic                  m1_rvalid,
  input  logic                  m1_rready,
  output logic [DATA_WIDTH-1:0] s_araddr,
  output logic                  s_arvalid,
  input  logic                  s_arready,
  input  logic [DATA_WIDTH-1:0] s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rvalid,
  output logic                  s_rready,
  output logic [1:0]            grant
);

  // Handshakes: a transfer happens on a rising clk edge where valid && ready.
  // valid never waits on ready; the arbiter only routes, it never creates a transfer.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    AR_M0 = 3'd1,
    AR_M1 = 3'd2,
    R_M0  = 3'd3,
    R_M1  = 3'd4
  } state_t;

  state_t state;

  // grant is registered alongside state so it is glitch-free for pipeline control.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (m1_arvalid) begin
            state <= AR_M1;
            grant <= 2'b10;
          end else if (m0_arvalid) begin
            state <= AR_M0;
            grant <= 2'b01;
          end
        end
        AR_M0: if (m0_arvalid && s_arready) state <= R_M0;
        AR_M1: if (m1_arvalid && s_arready) state <= R_M1;
        R_M0: begin
          if (s_rvalid && m0_rready) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        R_M1: begin
          if (s_rvalid && m1_rready) begin
            state <= IDLE;
            grant <= 2'b00;
          end
        end
        default: begin
          state <= IDLE;
          grant <= 2'b00;
        end
      endcase
    end
  end

  // Channel routing depends only on the registered state, never on the other master.
  always_comb begin
    s_araddr   = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m1_arready = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    case (state)
      AR_M0: begin
        s_araddr   = m0_araddr;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
      end
      AR_M1: begin
        s_araddr   = m1_araddr;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
      end
      R_M0: begin
        s_rready  = m0_rready;
        m0_rvalid = s_rvalid;
      end
      R_M1: begin
        s_rready  = m1_rready;
        m1_rvalid = s_rvalid;
      end
      default: ;
    endcase
  end

  // Read data and response are broadcast; only rvalid tells a master the beat is its own.
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;
  assign m0_rresp = s_rresp;
  assign m1_rresp = s_rresp;

endmodule

// File: tb/tb_ysyx_23060208_sram_rd_arbiter.sv
// Bench for the SRAM read arbiter: directed scenarios plus random traffic against a
// behavioural slave/memory model and per-master expected-response queues.
module tb_ysyx_23060208_sram_rd_arbiter;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] m0_araddr, m1_araddr, s_araddr;
  logic         m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic         m1_arvalid, m1_arready, m1_rvalid, m1_rready;
  logic [W-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]   m0_rresp, m1_rresp, s_rresp, grant;
  logic         s_arvalid, s_arready, s_rvalid, s_rready;

  always #5 clk = ~clk;

  ysyx_23060208_sram_rd_arbiter #(.DATA_WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
    .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
    .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .grant(grant)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {rresp, rdata} per master, in request order
  logic [W+1:0] exp0_q[$];
  logic [W+1:0] exp1_q[$];
  int           order_q[$];

  // Slave model state
  bit           sl_busy;
  logic [W-1:0] sl_addr;
  logic [1:0]   sl_resp;
  int           ar_cnt, r_cnt, ar_delay, r_delay;
  bit           err_next, rand_delays;
  int           ar_hs_n, r_hs_n, issued0, issued1, done0, done1;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], ~a[31:16]};
  endfunction

  task automatic slave_drive();
    s_arready = !sl_busy && (ar_cnt >= ar_delay);
    s_rvalid  = sl_busy && (r_cnt >= r_delay);
    s_rdata   = sl_busy ? mem_word(sl_addr) : W'($urandom);
    s_rresp   = sl_busy ? sl_resp : 2'b00;
  endtask

  task automatic model_clear();
    sl_busy = 0; ar_cnt = 0; r_cnt = 0;
    exp0_q.delete(); exp1_q.delete(); order_q.delete();
  endtask

  // One clock cycle: settle, check and record handshakes, cross the edge, update models.
  // Returns at the falling edge, which is where checks and new stimulus happen.
  task automatic tick();
    bit a0, a1, sa, sr, r0, r1, pv0, pv1, sav, srv, busy_pre;
    logic [1:0]   pg, resp_new;
    logic [W-1:0] sadr;
    logic [W+1:0] e;
    #1;
    a0 = m0_arvalid && m0_arready;  a1 = m1_arvalid && m1_arready;
    r0 = m0_rvalid && m0_rready;    r1 = m1_rvalid && m1_rready;
    sa = s_arvalid && s_arready;    sr = s_rvalid && s_rready;
    chk("ar_route", W'(sa), W'(a0 | a1));
    chk("r_route", W'(sr), W'(r0 | r1));
    chk("m0_rdata_bcast", m0_rdata, s_rdata);
    chk("m1_rdata_bcast", m1_rdata, s_rdata);
    chk("m0_rresp_bcast", W'(m0_rresp), W'(s_rresp));
    chk("m1_rresp_bcast", W'(m1_rresp), W'(s_rresp));
    if (grant != 2'b01) begin
      chk("m0_arready_gated", W'(m0_arready), 0);
      chk("m0_rvalid_gated", W'(m0_rvalid), 0);
    end
    if (grant != 2'b10) begin
      chk("m1_arready_gated", W'(m1_arready), 0);
      chk("m1_rvalid_gated", W'(m1_rvalid), 0);
    end
    resp_new = err_next ? 2'b10 : 2'b00;
    if (a0) exp0_q.push_back({resp_new, mem_word(m0_araddr)});
    if (a1) exp1_q.push_back({resp_new, mem_word(m1_araddr)});
    if (r0) begin
      chk("m0_r_expected", W'(exp0_q.size() > 0), 1);
      if (exp0_q.size() > 0) begin
        e = exp0_q.pop_front();
        chk("m0_rdata", m0_rdata, e[W-1:0]);
        chk("m0_rresp", W'(m0_rresp), W'(e[W+1:W]));
      end
      order_q.push_back(0); done0++;
    end
    if (r1) begin
      chk("m1_r_expected", W'(exp1_q.size() > 0), 1);
      if (exp1_q.size() > 0) begin
        e = exp1_q.pop_front();
        chk("m1_rdata", m1_rdata, e[W-1:0]);
        chk("m1_rresp", W'(m1_rresp), W'(e[W+1:W]));
      end
      order_q.push_back(1); done1++;
    end
    pg = grant; pv0 = m0_arvalid; pv1 = m1_arvalid;
    sav = s_arvalid; srv = s_rvalid; sadr = s_araddr; busy_pre = sl_busy;
    if (sa) ar_hs_n++;
    if (sr) r_hs_n++;
    @(posedge clk); #1;
    // From idle the LSU wins, otherwise the IFU, otherwise stay idle
    if (pg == 2'b00) chk("arb_pick", W'(grant), pv1 ? 32'd2 : (pv0 ? 32'd1 : 32'd0));
    if (a0) m0_arvalid = 0;
    if (a1) m1_arvalid = 0;
    if (sa) begin
      sl_busy = 1; sl_addr = sadr; sl_resp = resp_new; ar_cnt = 0; r_cnt = 0;
      if (rand_delays) err_next = ($urandom_range(0, 3) == 0);
    end else if (sav) begin
      ar_cnt++;
    end
    if (sr) begin
      sl_busy = 0; r_cnt = 0;
      if (rand_delays) begin
        ar_delay = $urandom_range(0, 3);
        r_delay  = $urandom_range(0, 3);
      end
    end else if (busy_pre && !srv) begin
      r_cnt++;
    end
    slave_drive();
    @(negedge clk);
  endtask

  task automatic drain(input int max);
    int c = 0;
    while (!(grant == 2'b00 && !m0_arvalid && !m1_arvalid && exp0_q.size() == 0 &&
             exp1_q.size() == 0) && c < max) begin
      tick(); c++;
    end
    chk("drain_done", W'(c < max), 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rv_seen;
    int c;
    rst = 1;
    m0_araddr = '0; m0_arvalid = 0; m0_rready = 1;
    m1_araddr = '0; m1_arvalid = 0; m1_rready = 1;
    ar_delay = 0; r_delay = 0; err_next = 0; rand_delays = 0;
    ar_hs_n = 0; r_hs_n = 0; issued0 = 0; issued1 = 0; done0 = 0; done1 = 0;
    model_clear();
    slave_drive();
    repeat (2) @(negedge clk);
    chk("rst_grant", W'(grant), 0);
    chk("rst_s_arvalid", W'(s_arvalid), 0);
    chk("rst_s_rready", W'(s_rready), 0);
    chk("rst_s_araddr", s_araddr, 0);
    chk("rst_m0_arready", W'(m0_arready), 0);
    chk("rst_m1_arready", W'(m1_arready), 0);
    chk("rst_m0_rvalid", W'(m0_rvalid), 0);
    chk("rst_m1_rvalid", W'(m1_rvalid), 0);
    rst = 0;
    tick();

    // IFU alone, zero-wait slave: IDLE, AR, R
    chk("ifu_c1_rvalid", W'(m0_rvalid), 0);
    m0_araddr = 32'h8000_0000; m0_arvalid = 1; issued0++;
    tick();
    chk("ifu_c2_grant", W'(grant), 1);
    chk("ifu_c2_s_arvalid", W'(s_arvalid), 1);
    chk("ifu_c2_s_araddr", s_araddr, 32'h8000_0000);
    chk("ifu_c2_m0_arready", W'(m0_arready), 1);
    tick();
    chk("ifu_c3_m0_rvalid", W'(m0_rvalid), 1);
    chk("ifu_c3_m0_rdata", m0_rdata, 32'h0000_0413);
    chk("ifu_c3_grant", W'(grant), 1);
    chk("ifu_c3_s_araddr", s_araddr, 0);
    tick();
    chk("ifu_c4_grant", W'(grant), 0);

    // Contention in the same idle cycle: LSU first, then IFU
    order_q.delete();
    m0_araddr = 32'h8000_0004; m0_arvalid = 1; issued0++;
    m1_araddr = 32'h8000_1000; m1_arvalid = 1; issued1++;
    tick();
    chk("cont_grant_lsu", W'(grant), 2);
    chk("cont_s_araddr", s_araddr, 32'h8000_1000);
    drain(40);
    chk("cont_served", W'(order_q.size()), 2);
    if (order_q.size() == 2) begin
      chk("cont_first", W'(order_q[0]), 1);
      chk("cont_second", W'(order_q[1]), 0);
    end

    // Backpressure on both channels of an LSU read
    ar_hs_n = 0; r_hs_n = 0; ar_delay = 3; r_delay = 5; m1_rready = 0; rv_seen = 0;
    m1_araddr = 32'h8000_2468; m1_arvalid = 1; issued1++;
    for (int i = 1; i <= 12; i++) begin
      tick();
      chk("bp_grant_hold", W'(grant), 2);
      chk("bp_s_arvalid", W'(s_arvalid), W'(i <= 4));
      chk("bp_m1_rvalid", W'(m1_rvalid), W'(i >= 10));
      if (m1_rvalid) begin
        if (rv_seen == 2) m1_rready = 1;
        rv_seen++;
      end
    end
    tick();
    chk("bp_grant_idle", W'(grant), 0);
    chk("bp_ar_hs_once", W'(ar_hs_n), 1);
    chk("bp_r_hs_once", W'(r_hs_n), 1);
    ar_delay = 0; r_delay = 0; m1_rready = 1;

    // SLVERR on an LSU read passes through unchanged
    err_next = 1;
    m1_araddr = 32'h8000_3000; m1_arvalid = 1; issued1++;
    tick(); tick();
    chk("err_m1_rvalid", W'(m1_rvalid), 1);
    chk("err_m1_rresp", W'(m1_rresp), 2);
    chk("err_m0_rvalid", W'(m0_rvalid), 0);
    err_next = 0;
    drain(20);

    // Isolation: LSU waits while the IFU read is in its R phase
    r_delay = 3;
    m0_araddr = 32'h8000_0040; m0_arvalid = 1; issued0++;
    tick(); tick();
    chk("iso_in_r_m0", W'(grant), 1);
    m1_araddr = 32'h8000_4000; m1_arvalid = 1; issued1++;
    c = 0;
    while (grant == 2'b01 && c < 20) begin
      chk("iso_m1_arready", W'(m1_arready), 0);
      tick(); c++;
    end
    chk("iso_idle_gap", W'(grant), 0);
    tick();
    chk("iso_ar_m1", W'(grant), 2);
    chk("iso_m1_arready_now", W'(m1_arready), 1);
    r_delay = 0;
    drain(20);

    // Asynchronous reset in the middle of an IFU R phase
    r_delay = 1; m0_rready = 0;
    m0_araddr = 32'h8000_0080; m0_arvalid = 1; issued0++;
    c = 0;
    while (!m0_rvalid && c < 20) begin tick(); c++; end
    chk("arst_pre_rvalid", W'(m0_rvalid), 1);
    #2 rst = 1;
    #1;
    chk("arst_grant", W'(grant), 0);
    chk("arst_s_arvalid", W'(s_arvalid), 0);
    chk("arst_m0_rvalid", W'(m0_rvalid), 0);
    chk("arst_s_rready", W'(s_rready), 0);
    model_clear(); r_delay = 0; m0_rready = 1; issued0--;
    slave_drive();
    @(negedge clk);
    rst = 0;
    tick();
    m0_araddr = 32'h8000_0008; m0_arvalid = 1; issued0++;
    tick(); tick();
    chk("arst_next_rvalid", W'(m0_rvalid), 1);
    chk("arst_next_rdata", m0_rdata, mem_word(32'h8000_0008));
    drain(20);
    done0 = issued0; done1 = issued1;

    // Random traffic with random delays, ready and error responses
    rand_delays = 1; issued0 = 0; issued1 = 0; done0 = 0; done1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if (!m0_arvalid && $urandom_range(0, 2) == 0) begin
        m0_araddr = W'($urandom); m0_arvalid = 1; issued0++;
      end
      if (!m1_arvalid && $urandom_range(0, 3) == 0) begin
        m1_araddr = W'($urandom); m1_arvalid = 1; issued1++;
      end
      m0_rready = $urandom_range(0, 1);
      m1_rready = $urandom_range(0, 1);
      tick();
    end
    m0_rready = 1; m1_rready = 1;
    drain(200);
    chk("rand_m0_complete", W'(done0), W'(issued0));
    chk("rand_m1_complete", W'(done1), W'(issued1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
